// File: rtl/instr_fetch_mem_if.sv
// Bus between the instruction-fetch memory and its controller.
// Groups the load, control and fetch signals, together with the results the memory reports back.
interface instr_fetch_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 16
);
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic              halt;
    logic              fetch_req;
    logic [PC_W-1:0]   pc_in;
    logic              stall;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              running;
    logic [ADDR_W:0]   ld_count;
    logic              oob_fault;

    modport master (
        output ld_en, ld_addr, ld_data, start, halt, fetch_req, pc_in, stall,
        input  instr_out, instr_valid, running, ld_count, oob_fault
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, halt, fetch_req, pc_in, stall,
        output instr_out, instr_valid, running, ld_count, oob_fault
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory: the LOAD phase fills it, and the RUN phase serves fetches with one cycle of latency.
// A PC outside the memory returns NOP_WORD and sets a fault flag that stays set until reset.
module instr_fetch_mem #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                PC_W     = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    instr_fetch_mem_if.slave bus
);
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_MAX = CNT_ONE << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic              running_q, running_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              oob_fault_q, oob_fault_d;

    logic              mem_we;
    logic              pc_in_range;
    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W-1:0] fetch_word;

    assign fetch_idx   = bus.pc_in[ADDR_W-1:0];
    assign pc_in_range = ((bus.pc_in >> ADDR_W) == '0);
    assign fetch_word  = pc_in_range ? mem[fetch_idx] : NOP_WORD;

    // Reset gates the write so that a load that coincides with reset is dropped.
    assign mem_we = (state_q == LOAD) && bus.ld_en && !rst;

    always_comb begin
        state_d       = state_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = instr_valid_q;
        ld_count_d    = ld_count_q;
        oob_fault_d   = oob_fault_q;

        case (state_q)
            LOAD: begin
                instr_valid_d = 1'b0;
                if (bus.ld_en && (ld_count_q != CNT_MAX)) begin
                    ld_count_d = ld_count_q + CNT_ONE;
                end
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    state_d       = LOAD;
                    instr_valid_d = 1'b0;
                    ld_count_d    = '0;
                end else if (!bus.stall) begin
                    if (bus.fetch_req) begin
                        instr_out_d   = fetch_word;
                        instr_valid_d = 1'b1;
                        if (!pc_in_range) begin
                            oob_fault_d = 1'b1;
                        end
                    end else begin
                        instr_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            running_q     <= 1'b0;
            ld_count_q    <= '0;
            oob_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            running_q     <= running_d;
            ld_count_q    <= ld_count_d;
            oob_fault_q   <= oob_fault_d;
        end
    end

    // The storage has no reset, so the loaded program survives a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.running     = running_q;
    assign bus.ld_count    = ld_count_q;
    assign bus.oob_fault   = oob_fault_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem.
// A table of vectors and a few hand-written sequences push their expected outputs into a queue, which is popped after each edge.
module tb_instr_fetch_mem;
    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        running;
        logic [8:0]  count;
        logic        oob;
    } exp_t;

    typedef struct {
        logic        ld_en;
        logic [7:0]  ld_addr;
        logic [15:0] ld_data;
        logic        start;
        logic        halt;
        logic        fetch_req;
        logic        stall;
        logic [15:0] pc_in;
        exp_t        e;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_t        exp_q [$];
    vec_t        tbl [$];
    logic [15:0] words [8];

    instr_fetch_mem_if #(.DATA_W(16), .ADDR_W(8), .PC_W(16)) bus ();

    instr_fetch_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic ld, logic [7:0] a, logic [15:0] d, logic s, logic h,
                                logic fr, logic st, logic [15:0] pc, logic [15:0] ei,
                                logic ev, logic er, logic [8:0] ec, logic eo);
        vec_t v;
        v.ld_en = ld;  v.ld_addr = a;  v.ld_data = d;  v.start = s;  v.halt = h;
        v.fetch_req = fr;  v.stall = st;  v.pc_in = pc;
        v.e.instr = ei;  v.e.valid = ev;  v.e.running = er;  v.e.count = ec;  v.e.oob = eo;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.ld_en     = v.ld_en;
        bus.ld_addr   = v.ld_addr;
        bus.ld_data   = v.ld_data;
        bus.start     = v.start;
        bus.halt      = v.halt;
        bus.fetch_req = v.fetch_req;
        bus.stall     = v.stall;
        bus.pc_in     = v.pc_in;
        exp_q.push_back(v.e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard empty actual=0 required=1", tag);
            return;
        end
        e = exp_q.pop_front();
        checkValue({tag, " instr_out"},   32'(bus.instr_out),   32'(e.instr));
        checkValue({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(e.valid));
        checkValue({tag, " running"},     32'(bus.running),     32'(e.running));
        checkValue({tag, " ld_count"},    32'(bus.ld_count),    32'(e.count));
        checkValue({tag, " oob_fault"},   32'(bus.oob_fault),   32'(e.oob));
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, " instr_out"},   32'(bus.instr_out),   32'h0);
        checkValue({tag, " instr_valid"}, 32'(bus.instr_valid), 32'h0);
        checkValue({tag, " running"},     32'(bus.running),     32'h0);
        checkValue({tag, " ld_count"},    32'(bus.ld_count),    32'h0);
        checkValue({tag, " oob_fault"},   32'(bus.oob_fault),   32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        words  = '{16'h1A80, 16'h6C88, 16'h4D10, 16'hC002, 16'h2B08, 16'h5B18, 16'h2B18, 16'hC03C};

        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 8'(i), words[i], i == 7, 0, 0, 0, 16'h0, 16'h0, 0, i == 7, 9'(i + 1), 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'(i), words[i], 1, 1, 9'd8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0003, 16'hC002, 1, 1, 9'd8, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0005, 16'hC002, 1, 1, 9'd8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0005, 16'h5B18, 1, 1, 9'd8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0005, 16'h5B18, 0, 1, 9'd8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h5B18, 0, 1, 9'd8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0100, 16'h0000, 1, 1, 9'd8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0002, 16'h4D10, 1, 1, 9'd8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'hFF07, 16'h0000, 1, 1, 9'd8, 1));
        tbl.push_back(mk(1, 8'h00, 16'hFFFF, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 9'd8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h1A80, 1, 1, 9'd8, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 16'h0001, 16'h1A80, 0, 0, 9'd0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h1A80, 0, 0, 9'd0, 1));
        tbl.push_back(mk(1, 8'h0A, 16'h1234, 0, 1, 0, 0, 16'h0, 16'h1A80, 0, 0, 9'd1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h1A80, 0, 1, 9'd1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h000A, 16'h1234, 1, 1, 9'd1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0007, 16'hC03C, 1, 1, 9'd1, 1));

        rst = 1'b1;
        bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.start = 0; bus.halt = 0;
        bus.fetch_req = 0; bus.stall = 0; bus.pc_in = 0;
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            runVec(tbl[i], $sformatf("vec%0d", i));

        // Raise reset asynchronously in RUN while a load and a fetch are being driven; neither may take effect.
        rst = 1'b1;
        bus.ld_en = 1; bus.ld_addr = 8'h01; bus.ld_data = 16'hDEAD;
        bus.fetch_req = 1; bus.pc_in = 16'h0002;
        #2;
        checkAllZero("async_rst");
        @(posedge clk);
        #1;
        checkAllZero("rst_edge");
        rst = 1'b0;
        runVec(mk(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 9'd0, 0), "post_rst_start");
        runVec(mk(0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h6C88, 1, 1, 9'd0, 0), "post_rst_pc1");
        runVec(mk(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h1A80, 1, 1, 9'd0, 0), "post_rst_pc0");
        runVec(mk(0, 0, 0, 0, 0, 1, 0, 16'h000A, 16'h1234, 1, 1, 9'd0, 0), "post_rst_pc10");
        runVec(mk(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h1234, 0, 0, 9'd0, 0), "halt2");

        for (int i = 0; i < 260; i++)
            runVec(mk(1, 8'(i), 16'(i), 0, 0, 0, 0, 16'h0, 16'h1234, 0, 0,
                      (i + 1 > 256) ? 9'd256 : 9'(i + 1), 0), $sformatf("sat%0d", i));
        runVec(mk(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h1234, 0, 1, 9'd256, 0), "sat_start");
        runVec(mk(0, 0, 0, 0, 0, 1, 0, 16'h00FF, 16'h00FF, 1, 1, 9'd256, 0), "sat_pc255");
        runVec(mk(0, 0, 0, 0, 0, 1, 0, 16'h0003, 16'h0103, 1, 1, 9'd256, 0), "sat_pc3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory index width; depth = 2^ADDR_W words.
REQ-003 SHALL have parameter PC_W, default 16, program-counter width; PC_W >= ADDR_W.
REQ-004 SHALL have parameter NOP_WORD, default 0, word returned for out-of-range fetches.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ld_en  input  1  write ld_data to ld_addr this cycle (LOAD state only).
REQ-008 ld_addr  input  ADDR_W  load write address.
REQ-009 ld_data  input  DATA_W  load write data.
REQ-010 start  input  1  pulse: LOAD -> RUN.
REQ-011 halt  input  1  pulse: RUN -> LOAD.
REQ-012 fetch_req  input  1  fetch request for pc_in (RUN only).
REQ-013 pc_in  input  PC_W  fetch address.
REQ-014 stall  input  1  hold current fetch output.
REQ-015 instr_out  output  DATA_W  registered fetched instruction.
REQ-016 instr_valid  output  1  instr_out holds a fetch result.
REQ-017 running  output  1  high in RUN state.
REQ-018 ld_count  output  ADDR_W+1  accepted load writes since last LOAD entry, saturating at 2^ADDR_W.
REQ-019 oob_fault  output  1  sticky: an out-of-range fetch occurred.

Function
REQ-020 SHALL implement two states, LOAD and RUN; reset state LOAD; running = (state == RUN).
REQ-021 In LOAD, ld_en=1 SHALL write ld_data to mem[ld_addr] at the clock edge and increment ld_count (saturating).
REQ-022 In RUN, ld_en SHALL be ignored: no write, no ld_count change.
REQ-023 start=1 in LOAD SHALL move to RUN next cycle; a same-cycle ld_en write SHALL still complete.
REQ-024 halt=1 in RUN SHALL move to LOAD next cycle, clear instr_valid and ld_count; start and halt both high SHALL act on current-state-relevant pulse only (start in LOAD, halt in RUN).
REQ-025 In RUN, fetch_req=1 and stall=0 SHALL register the fetch result into instr_out and set instr_valid=1 on the next edge (latency 1 cycle).
REQ-026 Fetch result: mem[pc_in[ADDR_W-1:0]] when pc_in[PC_W-1:ADDR_W] == 0; otherwise NOP_WORD and oob_fault set to 1.
REQ-027 stall=1 SHALL hold instr_out and instr_valid unchanged regardless of fetch_req; fetch_req under stall SHALL not set oob_fault.
REQ-028 fetch_req=0 and stall=0 in RUN SHALL clear instr_valid; instr_out holds last value.
REQ-029 In LOAD, fetch_req SHALL be ignored and instr_valid SHALL be 0.
REQ-030 oob_fault SHALL remain 1 until reset; halt does not clear it.
REQ-031 Memory array SHALL be a single write port, single synchronous read port; memory contents SHALL NOT be cleared by reset.
REQ-032 pc_in wrap: no pc arithmetic inside block; any pc_in value is handled per REQ-026.

Reset
REQ-033 rst=1 SHALL immediately force: state LOAD, instr_out=0, instr_valid=0, running=0, ld_count=0, oob_fault=0.
REQ-034 Reset asserted mid-fetch or mid-load SHALL abort the operation; a write coinciding with rst=1 SHALL not occur.
REQ-035 After rst deasserts, first edge SHALL behave as normal LOAD cycle.

Verification
REQ-036 Load 8 words (addr 0..7 = 0x1A80,0x6C88,0x4D10,0xC002,0x2B08,0x5B18,0x2B18,0xC03C), start -> running=1, ld_count=8.
REQ-037 RUN, fetch pc 0..7 back-to-back -> instr_out matches loaded words one cycle after each request, instr_valid=1 continuously.
REQ-038 fetch pc=3 then stall=1 for 3 cycles with pc_in=5 -> instr_out stays 0xC002, instr_valid=1; stall released -> 0x5B18.
REQ-039 fetch pc=0x0100 (ADDR_W=8) -> instr_out=NOP_WORD, instr_valid=1, oob_fault=1; later in-range fetches keep oob_fault=1.
REQ-040 RUN with ld_en=1 addr 0 data 0xFFFF, then fetch pc 0 -> 0x1A80 unchanged; halt -> running=0, instr_valid=0, ld_count=0.
REQ-041 Assert rst mid-RUN after oob fault -> all outputs 0 asynchronously; refetch after start returns previously loaded contents.
